ov7670_capture_ext: RTL

//  Parametrised OV7670 pixel-capture engine between the sensor bus and the

---
 rtl/ov7670_capture_ext_if.sv | 16 +
 rtl/ov7670_capture_ext.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ov7670_capture_ext_if.sv
// Sensor byte bus plus framebuffer write port of the OV7670 capture engine.
// The slave side is the capture engine; the master side is sensor plus BRAM.
interface ov7670_capture_ext_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DOUT_W = 2
);
  logic              vsync;
  logic              href;
  logic [7:0]        d;
  logic [ADDR_W-1:0] addr;
  logic [DOUT_W-1:0] dout;
  logic              we;

  modport master (output vsync, href, d, input addr, dout, we);
  modport slave  (input vsync, href, d, output addr, dout, we);
endinterface

// File: rtl/ov7670_capture_ext.sv
// OV7670 pixel-capture engine: frame-aligned start, 1/2-byte pixels, H/V decimation,
// window clipping, single-shot or continuous capture with frame status.
module ov7670_capture_ext #(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned H_DECIM  = 1,
  parameter int unsigned V_DECIM  = 1,
  parameter int unsigned BPP      = 1,
  parameter int unsigned DOUT_W   = 2,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic                pclk_12,
  input  logic                reset_n,
  input  logic                start_i,
  input  logic                single_i,
  ov7670_capture_ext_if.slave bus,
  output logic                busy_o,
  output logic                frame_done_o,
  output logic [FCNT_W-1:0]   frame_count_o,
  output logic                overrun_o
);
  localparam int unsigned CW  = $clog2(H_ACTIVE + 1);
  localparam int unsigned RW  = $clog2(V_ACTIVE + 1);
  localparam int unsigned HDW = (H_DECIM > 1) ? $clog2(H_DECIM) : 1;
  localparam int unsigned VDW = (V_DECIM > 1) ? $clog2(V_DECIM) : 1;

  typedef enum logic [1:0] {StIdle, StWaitVsync, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic              start_meta_q, start_s_q;
  logic              vsync_q, href_q;
  logic              single_q, single_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [HDW-1:0]    hdec_q, hdec_d;
  logic [VDW-1:0]    vdec_q, vdec_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d, addr_q, addr_d;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              we_q, we_d, done_q, done_d, ovr_q, ovr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              href_v, href_fall, vs_fall, vs_rise, pix_done, col_in, row_in;
  logic [15:0]       pix;

  always_comb begin
    // href during vsync is not part of any line
    href_v    = bus.href & ~bus.vsync;
    href_fall = href_q & ~href_v;
    vs_fall   = vsync_q & ~bus.vsync;
    vs_rise   = ~vsync_q & bus.vsync;
    pix_done  = href_v & ((BPP == 1) | phase_q);
    pix       = (BPP == 2) ? {hi_q, bus.d} : {bus.d, 8'h00};
    col_in    = col_q < CW'(H_ACTIVE);
    row_in    = row_q < RW'(V_ACTIVE);

    state_d     = state_q;
    single_d    = single_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    col_d       = col_q;
    row_d       = row_q;
    hdec_d      = hdec_q;
    vdec_d      = vdec_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    fcnt_d      = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_s_q) begin
          state_d = StWaitVsync;
          ovr_d   = 1'b0;
        end
      end
      StWaitVsync: begin
        if (!start_s_q) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d     = StCapture;
          single_d    = single_i;
          phase_d     = 1'b0;
          col_d       = '0;
          row_d       = '0;
          hdec_d      = '0;
          vdec_d      = '0;
          next_addr_d = '0;
          addr_d      = '0;
        end
      end
      StCapture: begin
        if (!start_s_q) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 1'b1;
          state_d = single_q ? StDone : StWaitVsync;
        end else begin
          if (href_v) begin
            phase_d = (BPP == 2) ? ~phase_q : 1'b0;
            if (!phase_q) hi_d = bus.d;
            if (!row_in) ovr_d = 1'b1;
          end else begin
            phase_d = 1'b0;
          end
          if (pix_done) begin
            if (!col_in) begin
              ovr_d = 1'b1;
            end else begin
              if (row_in && hdec_q == '0 && vdec_q == '0) begin
                we_d        = 1'b1;
                dout_d      = DOUT_W'(pix >> (16 - DOUT_W));
                addr_d      = next_addr_q;
                next_addr_d = next_addr_q + 1'b1;
              end
              // col saturates at H_ACTIVE so late pixels stay clipped
              col_d  = col_q + 1'b1;
              hdec_d = (hdec_q == HDW'(H_DECIM - 1)) ? '0 : hdec_q + 1'b1;
            end
          end
          if (href_fall) begin
            col_d  = '0;
            hdec_d = '0;
            row_d  = row_in ? row_q + 1'b1 : row_q;
            vdec_d = (vdec_q == VDW'(V_DECIM - 1)) ? '0 : vdec_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (!start_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      start_meta_q <= 1'b0;
      start_s_q    <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      single_q     <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      hdec_q       <= '0;
      vdec_q       <= '0;
      next_addr_q  <= '0;
      addr_q       <= '0;
      dout_q       <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      ovr_q        <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_meta_q <= start_i;
      start_s_q    <= start_meta_q;
      vsync_q      <= bus.vsync;
      href_q       <= href_v;
      single_q     <= single_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hdec_q       <= hdec_d;
      vdec_q       <= vdec_d;
      next_addr_q  <= next_addr_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      we_q         <= we_d;
      done_q       <= done_d;
      ovr_q        <= ovr_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign bus.addr      = addr_q;
  assign bus.dout      = dout_q;
  assign bus.we        = we_q;
  assign busy_o        = (state_q == StWaitVsync) || (state_q == StCapture);
  assign frame_done_o  = done_q;
  assign frame_count_o = fcnt_q;
  assign overrun_o     = ovr_q;
endmodule
